// File: rtl/spart_rx.sv
// SPART receive stage.
// Synchronises rxd, validates the start bit at mid-bit and shifts in an
// LSB-first 8N1 frame, paced by the 16x rx_enable tick from the baud generator.
// Posts each byte with a ready flag (rda) plus framing-error and overrun flags.
// Optional build macro: RX_MAJORITY_EN (2-of-3 vote per bit instead of one sample).
// rd/rda handshake: rd is a 1-clk pulse meaning "rx_data consumed"; it only has
// an effect while rda=1, and a post landing in the same clk as rd wins.
module spart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_enable,
    input  logic                 rxd,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_q, state_n;
    logic [3:0]           tick_q, tick_n;
    logic [BCW-1:0]       bit_q, bit_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rxd_s;
    logic                 bit_val;
    logic                 post;

    // Metastability synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef RX_MAJORITY_EN
    // Two earlier samples of the current bit; the third vote is the live rxd_s.
    logic [1:0] vote_q, vote_n;

    assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_s) | (vote_q[0] & rxd_s);

    // Vote capture at ticks 5,6 (start) or 13,14 (data/stop); cleared at each bit boundary.
    always_comb begin
        vote_n = vote_q;
        if (rx_enable) begin
            if (state_q == IDLE || tick_q == ((state_q == START) ? 4'd7 : 4'd15))
                vote_n = '0;
            else if ((state_q == START) ? (tick_q == 4'd5 || tick_q == 4'd6)
                                        : (tick_q == 4'd13 || tick_q == 4'd14))
                vote_n = {vote_q[0], rxd_s};
        end
    end

    // Vote register.
    always_ff @(posedge clk) begin
        if (rst) vote_q <= '0;
        else     vote_q <= vote_n;
    end
`else
    assign bit_val = rxd_s;
`endif

    // Receive FSM state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_n;
            tick_q  <= tick_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
        end
    end

    // Next-state logic; nothing moves except on an rx_enable tick.
    always_comb begin
        state_n = state_q;
        tick_n  = tick_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        post    = 1'b0;
        if (rx_enable) begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_n = START;
                        tick_n  = '0;
                    end
                end
                START: begin
                    tick_n = tick_q + 4'd1;
                    if (tick_q == 4'd7) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        // A start bit that is high at mid-bit was a glitch.
                        state_n = bit_val ? IDLE : DATA;
                    end
                end
                DATA: begin
                    tick_n = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        shift_n = {bit_val, shift_q[DATA_BITS-1:1]};
                        bit_n   = bit_q + BCW'(1);
                        if (bit_q == BCW'(DATA_BITS - 1))
                            state_n = STOP;
                    end
                end
                STOP: begin
                    tick_n = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        post    = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Bus-side registers: post a frame, or clear on a read of valid data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else if (post) begin
            rx_data     <= shift_q;
            rda         <= 1'b1;
            framing_err <= ~bit_val;
            if (rd)       overrun <= 1'b0;
            else if (rda) overrun <= 1'b1;
        end else if (rd && rda) begin
            rda     <= 1'b0;
            overrun <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: directed frame table, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_spart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_enable;
    logic       rxd;
    logic       rd;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    // Frame-level reference model of the bus-side registers.
    logic [7:0] exp_data;
    logic       exp_rda, exp_fe, exp_ovr;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rd_post;
        logic       rd_after;
        logic [7:0] e_data;
        logic       e_rda;
        logic       e_fe;
        logic       e_ov;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] glitch_exp;

    spart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .rx_enable  (rx_enable),
        .rxd        (rxd),
        .rd         (rd),
        .rx_data    (rx_data),
        .rda        (rda),
        .framing_err(framing_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, limit 3000000 ns");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input logic a,
                             input logic f, input logic o, input logic b);
        check({tag, ".rx_data"},     {24'd0, rx_data}, {24'd0, d});
        check({tag, ".rda"},         {31'd0, rda},         {31'd0, a});
        check({tag, ".framing_err"}, {31'd0, framing_err}, {31'd0, f});
        check({tag, ".overrun"},     {31'd0, overrun},     {31'd0, o});
        check({tag, ".busy"},        {31'd0, busy},        {31'd0, b});
    endtask

    // One tick slot = 4 clks: rxd changes at the start, the tick fires on the
    // 4th clk (after the synchroniser has settled), outputs sampled #1 later.
    task automatic slot(input logic v, input logic r);
        @(negedge clk) rxd = v;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk) begin rx_enable = 1'b1; rd = r; end
        @(posedge clk);
        #1;
        rx_enable = 1'b0;
        rd        = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) slot(1'b1, 1'b0);
    endtask

    // 16 start slots, 16 slots per data bit, stop held until its sample (slot 152).
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_post,
                              input int glitch, input int nslots);
        logic v;
        for (int i = 0; i < nslots; i++) begin
            if (i < 16)       v = 1'b0;
            else if (i < 144) v = b[(i - 16) / 16];
            else              v = stop;
            if (i == glitch) v = 1'b1;
            slot(v, (i == 152) && rd_post);
        end
    endtask

    task automatic rd_pulse();
        @(negedge clk) rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    task automatic model_rd();
        if (exp_rda) begin
            exp_rda = 1'b0;
            exp_ovr = 1'b0;
        end
    endtask

    task automatic model_post(input logic [7:0] b, input logic stop);
        if (exp_rda) exp_ovr = 1'b1;
        exp_rda  = 1'b1;
        exp_data = b;
        exp_fe   = ~stop;
    endtask

    initial begin
        //            data  stop rdp rda  e_data e_rda e_fe e_ov
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h0F, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h77, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0};
`ifdef RX_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h04;
`endif

        // Reset.
        rst = 1'b1; rx_enable = 1'b0; rxd = 1'b1; rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;
        idle(4);

        // Short low pulse on an idle line: start aborts at mid-bit.
        slot(1'b0, 1'b0);
        check("glitch.busy_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) slot(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) slot(1'b1, 1'b0);
        check("glitch.busy_t7", {31'd0, busy}, 32'd1);
        slot(1'b1, 1'b0);
        check_all("glitch.end", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Directed frame table.
        for (int k = 0; k < 6; k++) begin
            send_frame(tbl[k].data, tbl[k].stop, tbl[k].rd_post, -1, 153);
            check_all($sformatf("tbl%0d.post", k), tbl[k].e_data, tbl[k].e_rda,
                      tbl[k].e_fe, tbl[k].e_ov, 1'b0);
            if (tbl[k].rd_after) begin
                rd_pulse();
                check_all($sformatf("tbl%0d.rd", k), tbl[k].e_data, 1'b0, tbl[k].e_fe, 1'b0, 1'b0);
            end
            idle(2);
        end

        // Reset in the middle of data bit 4, with an unread byte pending.
        send_frame(8'h5A, 1'b1, 1'b0, -1, 153);
        idle(2);
        send_frame(8'hFF, 1'b1, 1'b0, -1, 86);
        check("midrst.busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        rxd = 1'b1;
        idle(6);
        send_frame(8'h81, 1'b1, 1'b0, -1, 153);
        check_all("midrst.next", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        rd_pulse();
        idle(2);

        // One-tick high glitch on the bit-2 sample tick of a 0x00 frame.
        send_frame(8'h00, 1'b1, 1'b0, 56, 153);
        check_all("bitglitch", glitch_exp, 1'b1, 1'b0, 1'b0, 1'b0);
        rd_pulse();
        check("bitglitch.rd", {31'd0, rda}, 32'd0);
        idle(2);

        // Randomized frames against the frame-level model.
        exp_data = glitch_exp; exp_rda = 1'b0; exp_fe = 1'b0; exp_ovr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            logic [7:0] b;
            logic       stop;
            int         mode;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 2);
            send_frame(b, stop, mode == 1, -1, 153);
            if (mode == 1) model_rd();
            model_post(b, stop);
            check_all($sformatf("rnd%0d.post", k), exp_data, exp_rda, exp_fe, exp_ovr, 1'b0);
            if (mode == 2) begin
                rd_pulse();
                model_rd();
                check_all($sformatf("rnd%0d.rd", k), exp_data, exp_rda, exp_fe, exp_ovr, 1'b0);
            end
            idle($urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
